pattern_gen_1_base: RTL and testbench
=====================================

# pattern_gen_1_base

Host-driven pattern generator for the debug toolset. It is the transmit-direction counterpart of the logic analyzer base: the analyzer samples FPGA channels and streams them to the host, while this block receives a sample table from the host over the Rx FIFO byte stream. It stores the table in an internal buffer and replays it onto FPGA channels at a fixed divided rate. Completion acknowledgements return to the host through the Tx FIFO.

## Interface
Parameters:
- N_CH, 8, output channel count; 1..8; each sample is the low N_CH bits of one byte.
- N_FIFO, 9, buffer address width; depth 2^N_FIFO samples.
- CLK_DIV, 1, clocks per played sample; ≥1.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- rx_rd_i  in  1  byte strobe from the Rx FIFO; rx_data_i is valid in the same cycle.
- rx_data_i  in  8  host byte.
- tx_data_o  out  8  acknowledge byte.
- tx_wr_o  out  1  one-cycle write strobe into the Tx FIFO.
- tx_full_i  in  1  Tx FIFO full; no write is issued while it is high.
- chn_o  out  N_CH  generated channels.
- busy_o  out  1  high in any state other than IDLE.
- dbg_o  out  4  {state[2:0], tx_pending}.

## Operation
Command bytes are parsed only in IDLE:
- 0x01 LOAD: followed by LEN_LO, LEN_HI, then LEN+1 sample bytes. LEN is 16 bits; only LEN[N_FIFO-1:0] is used.
- 0x02 RUN: play the buffer once.
- 0x03 LOOP: play the buffer repeatedly.
- Any other byte in IDLE is discarded.

State machine:
- IDLE → HDR0 on LOAD. HDR0 → HDR1 on the next strobe, capturing LEN_LO. HDR1 → DATA on the next strobe, capturing LEN_HI and clearing the write address.
- DATA: each strobe writes mem[waddr] = rx_data_i[N_CH-1:0] and increments waddr. When the byte at waddr==LEN is written, the block queues ack 0x5A and returns to IDLE.
- IDLE → PLAY on RUN or LOOP; raddr=0 and the loop flag is latched.
- PLAY: advances raddr every CLK_DIV cycles.
  - At raddr==LEN with the loop flag clear, the last sample is held for its full CLK_DIV period, then the block enters DONE.
  - With the loop flag set, raddr wraps to 0 with no gap.
- While in PLAY, only 0x04 STOP is recognised and all other bytes are discarded. STOP clears the loop flag, so playback ends after the current pass.
- 0x04 in IDLE is discarded.
- DONE: queues ack 0xA5 and returns to IDLE.

Outputs and acknowledges:
- chn_o keeps the last played sample indefinitely; LOAD does not change it.
- RUN or LOOP issued before any LOAD plays the buffer contents, which are undefined, using LEN=0.
- Ack path: a one-entry pending register. tx_wr_o pulses on the first cycle with pending set and tx_full_i low, then pending clears.
- The FSM does not leave DONE, and does not leave DATA on its final byte, while a previous ack is still pending. Acks are never dropped.

## Timing
- Reset values: chn_o=0, tx_wr_o=0, tx_data_o=0, busy_o=0, state=IDLE, pending=0, LEN=0, waddr=raddr=0. Buffer contents are not reset.
- Reset asserted mid-load or mid-play aborts immediately. chn_o goes to 0 asynchronously.
- Buffer read is synchronous. If the RUN/LOOP strobe arrives at cycle t, PLAY is entered at t+1 and chn_o=mem[0] from t+2.
- Sample k appears at t+2+k·CLK_DIV.
- Single run: the last sample is held CLK_DIV cycles; DONE follows; tx_wr_o pulses at the earliest one cycle later, given tx_full_i low.
- Load ack: tx_wr_o pulses one cycle after the final data strobe, given tx_full_i low.
- Strobes may arrive on consecutive cycles; every byte is consumed in one cycle with no backpressure on Rx.
- LEN covering the full depth (2^N_FIFO−1) fills the buffer exactly. waddr wraps modulo 2^N_FIFO and never exceeds LEN.

## Test plan
- Reset: hold rst_n_i low with random inputs. Required: chn_o=0, tx_wr_o=0, busy_o=0. Release reset, send 0x02. Required: PLAY entered without hang.
- Load then run: send 01 03 00 11 22 33 44, then 02, with CLK_DIV=1. Required:
  - tx 0x5A once.
  - chn_o = 11,22,33,44 on consecutive cycles starting 2 cycles after the RUN strobe.
  - tx 0xA5 once; chn_o stays 0x44.
- Divider and loop: CLK_DIV=3, table 01 02, command LOOP. Required: pattern 01,01,01,02,02,02 repeats with no gap. Send 04 mid-pass. Required: the pass completes, ends on 02, then 0xA5.
- Tx backpressure: hold tx_full_i high through the end of a RUN. Required: no tx_wr_o and state stays DONE. Release tx_full_i. Required: a single 0xA5 pulse.
- Discard rules: bytes 07 in IDLE and 01 during PLAY are ignored; the pattern is unchanged and no acks are produced apart from 0xA5 at the end.
- Boundaries: LEN=0 (one sample) plays one sample for CLK_DIV cycles. LEN=2^N_FIFO−1 fills the whole buffer and replays it exactly. Reset asserted mid-DATA, then a fresh LOAD, works correctly.

Source files
------------

// File: rtl/pattern_gen_1_base.sv
// Host-driven pattern generator. The host sends a sample table over the Rx
// byte stream (LOAD). The table sits in an internal buffer and is replayed
// onto chn_o once (RUN) or repeatedly (LOOP) at one sample per CLK_DIV
// clocks. Completion acks go back to the host through a one-entry pending
// register that drains into the Tx FIFO.
//
// Handshakes: rx_rd_i is a pure strobe. Each byte is consumed in the cycle
// it is presented and Rx is never backpressured. tx_wr_o is high for exactly
// the cycles where an ack is pending and tx_full_i is low. Each such cycle
// transfers tx_data_o into the Tx FIFO.
module pattern_gen_1_base #(
  parameter int N_CH    = 8,
  parameter int N_FIFO  = 9,
  parameter int CLK_DIV = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            rx_rd_i,
  input  logic [7:0]      rx_data_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_wr_o,
  input  logic            tx_full_i,
  output logic [N_CH-1:0] chn_o,
  output logic            busy_o,
  output logic [3:0]      dbg_o
);

  localparam int DEPTH = 1 << N_FIFO;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_LOOP = 8'h03;
  localparam logic [7:0] CMD_STOP = 8'h04;
  localparam logic [7:0] ACK_LOAD = 8'h5A;
  localparam logic [7:0] ACK_DONE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR0 = 3'd1,
    S_HDR1 = 3'd2,
    S_DATA = 3'd3,
    S_PLAY = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic                pending_q, pending_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [N_FIFO-1:0]   len_q, len_d;
  logic [N_FIFO-1:0]   waddr_q, waddr_d;
  logic [N_FIFO-1:0]   raddr_q, raddr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                loop_q, loop_d;
  logic [N_CH-1:0]     chn_q, chn_d;
  // The final data byte was written, but the ack slot was still occupied.
  logic                hold_q, hold_d;

  logic [N_CH-1:0]     mem [DEPTH];
  logic                mem_we;
  logic [15:0]         len_full;
  logic                tx_wr;
  logic                ack_free;

  // An ack can be queued when the slot is empty or is being drained this cycle.
  assign tx_wr    = pending_q & ~tx_full_i;
  assign ack_free = ~pending_q | tx_wr;
  assign len_full = {rx_data_i, len_lo_q};

  // Next-state and datapath logic for the command parser and player.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tx_data_d = tx_data_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    div_d     = div_q;
    loop_d    = loop_q;
    chn_d     = chn_q;
    hold_d    = hold_q;
    mem_we    = 1'b0;

    if (tx_wr) pending_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_rd_i) begin
          if (rx_data_i == CMD_LOAD) begin
            state_d = S_HDR0;
          end else if (rx_data_i == CMD_RUN || rx_data_i == CMD_LOOP) begin
            state_d = S_PLAY;
            raddr_d = '0;
            div_d   = '0;
            loop_d  = (rx_data_i == CMD_LOOP);
          end
        end
      end
      S_HDR0: begin
        if (rx_rd_i) begin
          len_lo_d = rx_data_i;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (rx_rd_i) begin
          len_d   = len_full[N_FIFO-1:0];
          waddr_d = '0;
          hold_d  = 1'b0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hold_q) begin
          // Table complete. Wait for the ack slot and ignore further bytes.
          if (ack_free) begin
            pending_d = 1'b1;
            tx_data_d = ACK_LOAD;
            hold_d    = 1'b0;
            state_d   = S_IDLE;
          end
        end else if (rx_rd_i) begin
          mem_we = 1'b1;
          if (waddr_q == len_q) begin
            if (ack_free) begin
              pending_d = 1'b1;
              tx_data_d = ACK_LOAD;
              state_d   = S_IDLE;
            end else begin
              hold_d = 1'b1;
            end
          end else begin
            waddr_d = waddr_q + N_FIFO'(1);
          end
        end
      end
      S_PLAY: begin
        // The registered read of mem[raddr] is what drives chn_o.
        chn_d = mem[raddr_q];
        if (rx_rd_i && rx_data_i == CMD_STOP) loop_d = 1'b0;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (raddr_q == len_q) begin
            if (loop_q) raddr_d = '0;
            else        state_d = S_DONE;
          end else begin
            raddr_d = raddr_q + N_FIFO'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        if (ack_free) begin
          pending_d = 1'b1;
          tx_data_d = ACK_DONE;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      pending_q <= 1'b0;
      tx_data_q <= 8'h00;
      len_lo_q  <= 8'h00;
      len_q     <= '0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      div_q     <= '0;
      loop_q    <= 1'b0;
      chn_q     <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      tx_data_q <= tx_data_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      div_q     <= div_d;
      loop_q    <= loop_d;
      chn_q     <= chn_d;
      hold_q    <= hold_d;
    end
  end

  // Sample buffer write port. The contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[waddr_q] <= rx_data_i[N_CH-1:0];
  end

  assign tx_wr_o   = tx_wr;
  assign tx_data_o = tx_data_q;
  assign chn_o     = chn_q;
  assign busy_o    = (state_q != S_IDLE);
  assign dbg_o     = {state_q, pending_q};

endmodule

// File: tb/tb_pattern_gen_1_base.sv
// Bench for pattern_gen_1_base. There are two instances that share the Rx
// and Tx-full stimulus:
//   - dut_a: 8 channels, CLK_DIV=1
//   - dut_b: 5 channels, CLK_DIV=3
// Both use a 64-entry buffer. Every cycle, chn_o, dbg_o and the Tx writes
// are recorded by cycle number. Expected output is computed from the table
// model: sample k of a play started at cycle t is shown from t+2+k*D.
module tb_pattern_gen_1_base;
  localparam int NF    = 6;
  localparam int DEPTH = 64;
  localparam int DA    = 1;
  localparam int DB    = 3;
  localparam int MAXC  = 8192;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       rx_rd_i;
  logic [7:0] rx_data_i;
  logic       tx_full_i;

  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_wr_a, tx_wr_b;
  logic [7:0] chn_a;
  logic [4:0] chn_b;
  logic       busy_a, busy_b;
  logic [3:0] dbg_a, dbg_b;

  pattern_gen_1_base #(.N_CH(8), .N_FIFO(NF), .CLK_DIV(DA)) dut_a (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_rd_i(rx_rd_i), .rx_data_i(rx_data_i),
    .tx_data_o(tx_data_a), .tx_wr_o(tx_wr_a), .tx_full_i(tx_full_i),
    .chn_o(chn_a), .busy_o(busy_a), .dbg_o(dbg_a)
  );

  pattern_gen_1_base #(.N_CH(5), .N_FIFO(NF), .CLK_DIV(DB)) dut_b (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_rd_i(rx_rd_i), .rx_data_i(rx_data_i),
    .tx_data_o(tx_data_b), .tx_wr_o(tx_wr_b), .tx_full_i(tx_full_i),
    .chn_o(chn_b), .busy_o(busy_b), .dbg_o(dbg_b)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor (negedge sampling) ----------------
  logic [7:0]  tr    [2][MAXC];
  logic [3:0]  st    [2][MAXC];
  logic [39:0] obs_a[$], obs_b[$];
  logic [39:0] exp_q_a[$], exp_q_b[$];

  always @(negedge clk_i) begin
    if (cyc < MAXC) begin
      tr[0][cyc] = chn_a;
      tr[1][cyc] = {3'b000, chn_b};
      st[0][cyc] = dbg_a;
      st[1][cyc] = dbg_b;
    end
    if (tx_wr_a) obs_a.push_back({cyc[31:0], tx_data_a});
    if (tx_wr_b) obs_b.push_back({cyc[31:0], tx_data_b});
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mdl_mem [DEPTH];
  int         mdl_len = 0;

  // ---------------- drivers ----------------
  // All drivers start and end at posedge+#1.
  task automatic strobe(input logic [7:0] b, output int c);
    rx_rd_i   = 1'b1;
    rx_data_i = b;
    c = cyc;
    @(posedge clk_i); #1;
    rx_rd_i   = 1'b0;
    rx_data_i = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b);
    int c;
    strobe(b, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc <= c) begin @(posedge clk_i); #1; end
  endtask

  logic [7:0] ld_q[$];

  task automatic do_load(input int len16, input bit exp_ack);
    int c;
    int n;
    send(8'h01);
    send(8'(len16));
    send(8'(len16 >> 8));
    n = ld_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && $urandom_range(0, 3) == 0) idle(1);
      strobe(ld_q[i], c);
      mdl_mem[i] = ld_q[i];
    end
    mdl_len = len16 & (DEPTH - 1);
    if (exp_ack) begin
      exp_q_a.push_back({32'(c + 1), 8'h5A});
      exp_q_b.push_back({32'(c + 1), 8'h5A});
    end
  endtask

  function automatic int play_end(input int t, input int s, input int dv);
    int l;
    int p;
    l = mdl_len + 1;
    p = 1;
    if (s >= 0) while (t + p * l * dv < s + 1) p++;
    return t + 1 + p * l * dv;   // cycle in which DONE is held
  endfunction

  // Check a play started by a RUN/LOOP strobe at cycle t, with an optional
  // STOP at cycle s (-1 if none).
  task automatic play_check(input int t, input int s, input bit chk_chn, input bit push_ack);
    int dv;
    int l;
    int done;
    logic [7:0] mask;
    logic [7:0] e;
    for (int d = 0; d < 2; d++) begin
      dv   = d ? DB : DA;
      mask = d ? 8'h1F : 8'hFF;
      l    = mdl_len + 1;
      done = play_end(t, s, dv);
      check_eq($sformatf("play_enter_%0d", d), 64'(st[d][t + 1][3:1]), 64'd4);
      check_eq($sformatf("play_last_%0d", d), 64'(st[d][done - 1][3:1]), 64'd4);
      check_eq($sformatf("done_state_%0d", d), 64'(st[d][done][3:1]), 64'd5);
      e = 8'h00;
      if (chk_chn) begin
        for (int c = t + 2; c <= done; c++) begin
          e = mdl_mem[((c - t - 2) / dv) % l] & mask;
          check_eq($sformatf("chn_%0d_c%0d", d, c), 64'(tr[d][c]), 64'(e));
        end
        for (int c = done + 1; c <= done + 4; c++)
          check_eq($sformatf("chn_hold_%0d_c%0d", d, c), 64'(tr[d][c]), 64'(e));
      end
      if (push_ack) begin
        if (d == 0) exp_q_a.push_back({32'(done + 1), 8'hA5});
        else        exp_q_b.push_back({32'(done + 1), 8'hA5});
      end
    end
  endtask

  task automatic ack_check();
    logic [39:0] e;
    logic [39:0] o;
    while (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      o = (obs_a.size() > 0) ? obs_a.pop_front() : 40'hDEAD;
      check_eq("ack_a", 64'(o), 64'(e));
    end
    while (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      o = (obs_b.size() > 0) ? obs_b.pop_front() : 40'hDEAD;
      check_eq("ack_b", 64'(o), 64'(e));
    end
    check_eq("ack_a_extra", 64'(obs_a.size()), 64'd0);
    check_eq("ack_b_extra", 64'(obs_b.size()), 64'd0);
    obs_a.delete();
    obs_b.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int s;
    int r;
    int e;
    rst_n_i   = 1'b0;
    rx_rd_i   = 1'b0;
    rx_data_i = 8'h00;
    tx_full_i = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      rx_rd_i   = 1'($urandom);
      rx_data_i = 8'($urandom);
      tx_full_i = 1'($urandom);
      @(negedge clk_i);
      check_eq("rst_chn_a", 64'(chn_a), 64'd0);
      check_eq("rst_chn_b", 64'(chn_b), 64'd0);
      check_eq("rst_txwr", 64'({tx_wr_a, tx_wr_b}), 64'd0);
      check_eq("rst_busy", 64'({busy_a, busy_b}), 64'd0);
      check_eq("rst_dbg", 64'({dbg_a, dbg_b}), 64'd0);
      check_eq("rst_txdata", 64'({tx_data_a, tx_data_b}), 64'd0);
    end
    @(posedge clk_i); #1;
    rx_rd_i = 1'b0; tx_full_i = 1'b0;
    rst_n_i = 1'b1;
    idle(2);

    // RUN before any LOAD plays one (undefined) sample with LEN=0.
    strobe(8'h02, t);
    wait_cyc(play_end(t, -1, DB) + 8);
    play_check(t, -1, 1'b0, 1'b1);
    ack_check();

    // Load four samples, then run once.
    ld_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_load(3, 1'b1);
    idle(3);
    strobe(8'h02, t);
    wait_cyc(play_end(t, -1, DB) + 8);
    play_check(t, -1, 1'b1, 1'b1);
    ack_check();

    // Loop with discards, then STOP mid-pass.
    ld_q = '{8'h01, 8'h02};
    do_load(1, 1'b1);
    idle(2);
    send(8'h07);
    send(8'h04);
    idle(1);
    strobe(8'h03, t);
    idle($urandom_range(3, 8));
    send(8'h01);
    idle($urandom_range(2, 12));
    strobe(8'h04, s);
    wait_cyc(play_end(t, s, DB) + 8);
    play_check(t, s, 1'b1, 1'b1);
    ack_check();

    // Tx backpressure: the load ack is stuck, so DONE must stall.
    tx_full_i = 1'b1;
    ld_q.delete();
    for (int i = 0; i < 5; i++) ld_q.push_back(8'($urandom));
    do_load(4, 1'b0);
    idle(2);
    strobe(8'h02, t);
    e = play_end(t, -1, DB);
    wait_cyc(e + 10);
    play_check(t, -1, 1'b1, 1'b0);
    @(negedge clk_i);
    check_eq("stall_dbg_a", 64'(dbg_a), 64'hB);
    check_eq("stall_dbg_b", 64'(dbg_b), 64'hB);
    check_eq("stall_no_wr_a", 64'(obs_a.size()), 64'd0);
    check_eq("stall_no_wr_b", 64'(obs_b.size()), 64'd0);
    @(posedge clk_i); #1;
    tx_full_i = 1'b0;
    r = cyc;
    exp_q_a.push_back({32'(r), 8'h5A});
    exp_q_a.push_back({32'(r + 1), 8'hA5});
    exp_q_b.push_back({32'(r), 8'h5A});
    exp_q_b.push_back({32'(r + 1), 8'hA5});
    idle(6);
    ack_check();

    // LEN=0: one sample held for one divider period.
    ld_q = '{8'($urandom_range(1, 255))};
    do_load(0, 1'b1);
    strobe(8'h02, t);
    wait_cyc(play_end(t, -1, DB) + 8);
    play_check(t, -1, 1'b1, 1'b1);
    ack_check();

    // Full depth, with high LEN bits that must be ignored.
    ld_q.delete();
    for (int i = 0; i < DEPTH; i++) ld_q.push_back(8'($urandom));
    do_load(16'h013F, 1'b1);
    idle(1);
    strobe(8'h02, t);
    wait_cyc(play_end(t, -1, DB) + 8);
    play_check(t, -1, 1'b1, 1'b1);
    ack_check();

    // Reset in the middle of DATA, then a fresh load.
    send(8'h01);
    send(8'h10);
    send(8'h00);
    for (int i = 0; i < 4; i++) begin
      mdl_mem[i] = 8'($urandom);
      send(mdl_mem[i]);
    end
    #2;
    rst_n_i = 1'b0;
    #1;
    check_eq("arst_chn_a", 64'(chn_a), 64'd0);
    check_eq("arst_chn_b", 64'(chn_b), 64'd0);
    check_eq("arst_busy", 64'({busy_a, busy_b}), 64'd0);
    mdl_len = 0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    idle(2);
    obs_a.delete();
    obs_b.delete();
    ld_q.delete();
    for (int i = 0; i < 6; i++) ld_q.push_back(8'($urandom));
    do_load(5, 1'b1);
    strobe(8'h02, t);
    wait_cyc(play_end(t, -1, DB) + 8);
    play_check(t, -1, 1'b1, 1'b1);
    ack_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
